// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch sequencer: one outstanding imem request,
// valid/ready hand-off to decode, and redirect handling with in-flight discard.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | first cycle out of reset, nothing issued
// REQ    | imem_req_o high at pc_q, waiting for grant
// WAIT   | granted, waiting for the response that decode will see
// DROP   | granted, but a redirect happened; swallow the response
// HOLD   | instruction presented to decode until accepted or redirected
module pc_fetch_ctrl #(
   parameter int unsigned      XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      pcsrc_i,
   input  logic [XLEN-1:0] jump_target_i,
   input  logic [XLEN-1:0] indj_base_i,
   input  logic [11:0]     indj_imm_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            if_valid_o,
   output logic [XLEN-1:0] if_instr_o,
   output logic [XLEN-1:0] if_pc_o,
   input  logic            if_ready_i,
   output logic            misaligned_o,
   output logic [XLEN-1:0] misaligned_addr_o
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;

   localparam logic [1:0]      PCSRC_JUMP = 2'd1;
   localparam logic [1:0]      PCSRC_INDJ = 2'd2;
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
   localparam logic [XLEN-1:0] BIT0_MASK  = ~XLEN'(1);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            if_valid_q, if_valid_d;
   logic [XLEN-1:0] if_instr_q, if_instr_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic            mis_q, mis_d;
   logic [XLEN-1:0] mis_addr_q, mis_addr_d;

   logic [XLEN-1:0] indj_sum;
   logic [XLEN-1:0] target;
   logic            redir;
   logic            redir_ok;

   always_comb begin
      indj_sum = indj_base_i + {{(XLEN-12){indj_imm_i[11]}}, indj_imm_i};
      target   = (pcsrc_i == PCSRC_JUMP) ? jump_target_i : (indj_sum & BIT0_MASK);
      redir    = (pcsrc_i == PCSRC_JUMP) || (pcsrc_i == PCSRC_INDJ);
      redir_ok = redir && !target[1];
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      mis_d      = redir && target[1];
      mis_addr_d = mis_d ? target : mis_addr_q;

      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (imem_gnt_i) state_d = redir_ok ? S_DROP : S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid_i) begin
               if (redir_ok) begin
                  state_d = S_REQ;
               end else begin
                  state_d    = S_HOLD;
                  if_valid_d = 1'b1;
                  if_instr_d = imem_rdata_i;
                  if_pc_d    = pc_q;
               end
            end else if (redir_ok) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_rvalid_i) state_d = S_REQ;
         end
         S_HOLD: begin
            // a redirect wins over a simultaneous accept
            if (redir_ok) begin
               if_valid_d = 1'b0;
               state_d    = S_REQ;
            end else if (if_ready_i) begin
               if_valid_d = 1'b0;
               pc_d       = pc_q + PC_STEP;
               state_d    = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (redir_ok) pc_d = {target[XLEN-1:2], 2'b00};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_instr_q <= '0;
         if_pc_q    <= '0;
         mis_q      <= 1'b0;
         mis_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_valid_q <= if_valid_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
         mis_q      <= mis_d;
         mis_addr_q <= mis_addr_d;
      end
   end

   assign imem_req_o        = (state_q == S_REQ);
   assign imem_addr_o       = pc_q;
   assign if_valid_o        = if_valid_q;
   assign if_instr_o        = if_instr_q;
   assign if_pc_o           = if_pc_q;
   assign misaligned_o      = mis_q;
   assign misaligned_addr_o = mis_addr_q;

endmodule
